// File: rtl/peak_detect4.sv
// Frame-based peak detector: tracks the running maximum of a 4-bit sample
// stream and the index of its first occurrence, then presents the result
// on an output handshake at the end of each frame.

// 4-bit strict unsigned greater-than compare.
module greaterthan4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt_o
);

  assign gt_o = (a_i > b_i);

endmodule

module peak_detect4 #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [3:0]       in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       out_max_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             busy_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       max_q, max_d;
  logic             gt;

  greaterthan4bit u_gt (
    .a_i  (in_data_i),
    .b_i  (max_q),
    .gt_o (gt)
  );

  // Handshake flags come straight from the state register.
  assign in_ready_o  = (state_q == StAccum);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign out_max_o   = max_q;
  assign out_idx_o   = idx_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StAccum;
          cnt_d   = '0;
          max_d   = '0;
          idx_d   = '0;
        end
      end
      StAccum: begin
        if (in_valid_i) begin
          // First sample seeds the maximum; later ones replace it only when
          // strictly larger, so ties keep the earliest index.
          if (cnt_q == '0) begin
            max_d = in_data_i;
            idx_d = '0;
          end else if (gt) begin
            max_d = in_data_i;
            idx_d = cnt_q;
          end
          if (cnt_q == LastIdx) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

endmodule
